// File: rtl/wallace_cpa_pipe.sv
// wallace_cpa_pipe
//   Final carry-propagate adder for the Wallace multiplier. It adds the sum row
//   and the carry row from the compression tree in two pipeline stages:
//   stage 1 adds the low half and registers the carry out of that half.
//   Stage 2 adds the high half with that registered carry. The longest ripple
//   is therefore W/2 bits. Both sides use a valid/ready handshake, and the
//   block sustains one result per cycle.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   row_s/row_c carry a valid row pair
//   in_ready   pair is accepted this cycle (combinational from out_ready)
//   row_s      sum row, column aligned
//   row_c      carry row, already shifted into its column
//   out_valid  prod/cout carry a valid result
//   out_ready  consumer takes the result this cycle
//   prod       (row_s + row_c) mod 2^W
//   cout       bit W of row_s + row_c
module wallace_cpa_pipe #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] row_s,
  input  logic [W-1:0] row_c,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] prod,
  output logic         cout
);

  localparam int H = W / 2;

  // Stage 1: low-half sum, its carry, and the raw high halves of both rows
  logic         r_s1_v;
  logic [H-1:0] r_s1_lo;
  logic         r_s1_c;
  logic [H-1:0] r_s1_hs;
  logic [H-1:0] r_s1_hc;

  // Stage 2: the output register
  logic         r_s2_v;
  logic [W-1:0] r_prod;
  logic         r_cout;

  logic         w_adv1;
  logic         w_adv2;
  logic [H:0]   w_lo_sum;
  logic [H:0]   w_hi_sum;

  // Low-half add, H+1 bits wide so that the top bit is the carry into the high half
  assign w_lo_sum = {1'b0, row_s[H-1:0]} + {1'b0, row_c[H-1:0]};

  // High-half add with the registered low carry; the top bit becomes cout
  assign w_hi_sum = {1'b0, r_s1_hs} + {1'b0, r_s1_hc} + {{H{1'b0}}, r_s1_c};

  // There is room when either stage is empty or the output drains this cycle.
  // This gives a combinational path from out_ready to in_ready, which is intentional.
  assign in_ready = !r_s1_v || !r_s2_v || out_ready;

  assign w_adv2 = r_s1_v && (!r_s2_v || out_ready);
  assign w_adv1 = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_v <= 1'b0;
      r_prod <= '0;
      r_cout <= 1'b0;
    end else if (w_adv2) begin
      r_s2_v <= 1'b1;
      r_prod <= {w_hi_sum[H-1:0], r_s1_lo};
      r_cout <= w_hi_sum[H];
    end else if (out_ready) begin
      r_s2_v <= 1'b0;
    end
  end

  // S1 may load and drain into S2 on the same edge. In that case occupancy
  // is unchanged and no bubble is inserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v  <= 1'b0;
      r_s1_lo <= '0;
      r_s1_c  <= 1'b0;
      r_s1_hs <= '0;
      r_s1_hc <= '0;
    end else if (w_adv1) begin
      r_s1_v  <= 1'b1;
      r_s1_lo <= w_lo_sum[H-1:0];
      r_s1_c  <= w_lo_sum[H];
      r_s1_hs <= row_s[W-1:H];
      r_s1_hc <= row_c[W-1:H];
    end else if (w_adv2) begin
      r_s1_v <= 1'b0;
    end
  end

  assign out_valid = r_s2_v;
  assign prod      = r_prod;
  assign cout      = r_cout;

endmodule

// File: tb/tb_wallace_cpa_pipe.sv
module tb_wallace_cpa_pipe;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] row_s;
  logic [W-1:0] row_c;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] prod;
  logic         cout;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W:0] exp_q[$];

  wallace_cpa_pipe #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .row_s     (row_s),
    .row_c     (row_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .cout      (cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One cycle of stimulus: the inputs are driven at the negedge, acceptance is
  // decided just before the posedge, and the task returns 1 time unit after
  // the posedge.
  task automatic drive(input logic v, input logic [W-1:0] s, input logic [W-1:0] c,
                       input logic ordy, output logic acc);
    @(negedge clk);
    in_valid  = v;
    row_s     = s;
    row_c     = c;
    out_ready = ordy;
    #1;
    acc = v && in_ready;
    if (acc) exp_q.push_back({1'b0, s} + {1'b0, c});
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    logic acc;
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b1, acc);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor: pop the scoreboard on each output handshake, and check that the
  // output holds while it is stalled.
  initial begin
    logic       hold_v;
    logic [W:0] held;
    hold_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v && out_valid) chk("stall_hold", {cout, prod}, held);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_output: got 0x%0h with no pending pair", {cout, prod});
          end else begin
            chk("result", {cout, prod}, exp_q.pop_front());
          end
          hold_v = 1'b0;
        end else if (out_valid) begin
          hold_v = 1'b1;
          held   = {cout, prod};
        end else begin
          hold_v = 1'b0;
        end
      end
    end
  end

  initial begin
    logic acc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    row_s     = '0;
    row_c     = '0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_prod", prod, 0);
    chk("rst_cout", cout, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Carry crosses from the low half into the high half
    drive(1'b1, 16'h00FF, 16'h0001, 1'b1, acc);
    chk("carry_acc", acc, 1);
    chk("carry_lat1_valid", out_valid, 0);
    drive(1'b0, '0, '0, 1'b1, acc);
    chk("carry_lat2_valid", out_valid, 1);
    chk("carry_prod", prod, 16'h0100);
    chk("carry_cout", cout, 0);
    drain(3);

    // Full wrap, two pairs on consecutive cycles
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b1, acc);
    drive(1'b1, 16'h8000, 16'h8000, 1'b1, acc);
    chk("wrap1", {out_valid, cout, prod}, {1'b1, 1'b1, 16'h0000});
    drive(1'b0, '0, '0, 1'b1, acc);
    chk("wrap2", {out_valid, cout, prod}, {1'b1, 1'b1, 16'h0000});
    drain(3);

    // Back-to-back streaming
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'(i * 16'h1111), 16'h0F0F, 1'b1, acc);
      chk("stream_in_ready", acc, 1);
      if (i >= 1) chk("stream_out_valid", out_valid, 1);
    end
    drive(1'b0, '0, '0, 1'b1, acc);
    chk("stream_out_valid_last", out_valid, 1);
    drive(1'b0, '0, '0, 1'b1, acc);
    chk("stream_done", out_valid, 0);
    drain(2);

    // Backpressure: capacity is two entries
    drive(1'b1, 16'd1, 16'd1, 1'b0, acc);
    chk("bp_acc1", acc, 1);
    drive(1'b1, 16'd2, 16'd2, 1'b0, acc);
    chk("bp_acc2", acc, 1);
    chk("bp_in_ready_low", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'd3, 16'd3, 1'b0, acc);
      chk("bp_reject", acc, 0);
      chk("bp_prod_stall", {out_valid, prod}, {1'b1, 16'h0002});
    end
    drive(1'b1, 16'd3, 16'd3, 1'b1, acc);
    chk("bp_acc3_on_ready", acc, 1);
    drain(4);

    // Load and drain on the same edge with both stages full
    drive(1'b1, 16'h1234, 16'h1111, 1'b0, acc);
    drive(1'b1, 16'hA000, 16'h7000, 1'b0, acc);
    drive(1'b1, 16'h0F0F, 16'hF0F0, 1'b1, acc);
    chk("fd_acc", acc, 1);
    chk("fd_s2_moved", {out_valid, cout, prod}, {1'b1, 1'b1, 16'h1000});
    out_ready = 1'b0;
    #1;
    chk("fd_full", in_ready, 0);
    drain(4);

    // Reset with two pairs in flight
    drive(1'b1, 16'h0101, 16'h0202, 1'b0, acc);
    drive(1'b1, 16'h0303, 16'h0404, 1'b0, acc);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_prod", prod, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, '0, 1'b1, acc);
      chk("no_stale", out_valid, 0);
    end

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 9) < 7), acc);
    end
    drain(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/wallace_cpa_pipe.md
# wallace_cpa_pipe

Two-stage pipelined carry-propagate adder that consumes the two redundant rows (sum row and carry row) from the Wallace compression tree and produces the final binary product. It sits directly downstream of the full-adder column stacks and upstream of the multiplier result register. It splits the add into a low half and a high half. A registered carry passes between the halves, so the critical path is W/2 bits. A valid/ready handshake runs on both sides, with throughput of one result per cycle.

## Interface
- W, 16: row and product width. Must be even and at least 4. Half-width H = W/2.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  row_s/row_c hold a valid row pair.
- in_ready  output  1  block accepts a pair this cycle.
- row_s  input  W  sum row from the compression tree, column-aligned.
- row_c  input  W  carry row from the compression tree, already shifted to its column.
- out_valid  output  1  prod/cout hold a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- prod  output  W  (row_s + row_c) mod 2^W.
- cout  output  1  bit W of row_s + row_c.

## Operation
- A transfer happens on a clk edge when valid && ready on that side.
- Stage 1 register S1 contents:
  - s1_v
  - s1_lo = (row_s[H-1:0] + row_c[H-1:0]) mod 2^H
  - s1_c = carry out of that low add
  - s1_hs = row_s[W-1:H]
  - s1_hc = row_c[W-1:H]
- Stage 2 register S2 (output) contents:
  - s2_v
  - prod[H-1:0] = s1_lo
  - {cout, prod[W-1:H]} = s1_hs + s1_hc + s1_c, computed H+1 bits wide
- Advance conditions:
  - adv2 = s1_v && (!s2_v || out_ready)
  - adv1 = in_valid && in_ready
- in_ready = !s1_v || !s2_v || out_ready. This is combinational from out_ready. The path is allowed and documented.
- S2 update on each edge:
  - If adv2, S2 loads from S1 and s2_v becomes 1.
  - Else if out_ready, s2_v becomes 0.
  - Otherwise S2 holds.
- S1 update on each edge:
  - If adv1, S1 loads from the inputs and s1_v becomes 1.
  - Else if adv2, s1_v becomes 0.
  - Otherwise S1 holds.
- Simultaneous load of S1 and drain of S1 into S2 in the same edge is legal. Net occupancy is unchanged and no bubble is inserted.
- out_valid = s2_v. While out_valid is high and out_ready is low, prod and cout hold stable.
- Results leave in acceptance order. There is no reordering and no drop.
- Data registers update only on their load condition. When not loading they hold their old value, including when invalid.
- No overflow condition exists. cout carries the (W+1)-th bit, and the 2W-bit multiplier wrapper ignores it.

## Timing
- Reset (rst high, asynchronous):
  - s1_v = 0 and s2_v = 0
  - out_valid = 0, prod = 0, cout = 0
  - all S1 data = 0
  - in_ready = 1 while in reset and on the first cycle after
- Latency: a pair accepted at edge N gives out_valid = 1 after edge N+1, provided S2 was free or draining. The result is consumed at the first edge ≥ N+2 where out_ready is high.
- Throughput: one pair per cycle while out_ready is held high.
- Capacity: 2 entries.
  - With out_ready low, at most 2 pairs are accepted.
  - in_ready drops the cycle after the second acceptance.
  - in_ready rises again in the same cycle out_ready goes high (combinational path).
- Reset mid-operation discards both stages. No result for the discarded pairs ever appears.
- Empty pipeline with in_valid low: outputs hold, out_valid = 0.

## Test plan
- Low-half carry crossing (W=16): send row_s=0x00FF, row_c=0x0001 with out_ready=1. Required: out_valid is high two edges later, prod=0x0100, cout=0.
- Full wrap: send 0xFFFF + 0x0001, then 0x8000 + 0x8000. Required: prod=0x0000, cout=1 on consecutive cycles, for both pairs.
- Back-to-back streaming: 8 consecutive pairs row_s=i·0x1111, row_c=0x0F0F, with out_ready tied high. Required:
  - in_ready never drops.
  - out_valid is high for 8 consecutive cycles starting 2 cycles after the first accept.
  - Sums are correct and in order.
- Backpressure: out_ready=0, with 3 pairs offered (1+1, 2+2, 3+3). Required:
  - Pairs 1 and 2 are accepted and in_ready drops.
  - prod stays at 0x0002 while stalled.
  - Raising out_ready yields 0x0002, 0x0004, 0x0006 with no loss.
- Simultaneous fill/drain: S1 and S2 full, out_ready=1, in_valid=1 in the same cycle. Required: the new pair is accepted, the S2 result is consumed, S1 moves into S2, and occupancy stays at 2.
- Reset mid-flight: two pairs in the pipe, assert rst for 1 cycle. Required: out_valid=0, prod=0 and in_ready=1 immediately, and no stale result appears afterwards.
